pep_ks_cmd_sched: RTL

- Command scheduler placed between the PBS sequencer and the key-switch controller.
- Buffers key-switch commands from the sequencer and answers the key switch's command enquiries.
- Issues a command only when a KSK batch slot has been loaded, and bounds the number of in-flight commands to the KSK buffer depth.
- Tracks KSK load/consume pointer pulses and flags protocol violations.

---
 rtl/pep_ks_cmd_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pep_ks_cmd_sched.sv
// Key-switch command scheduler: buffers sequencer commands and releases one per
// key-switch enquiry once a KSK batch slot is loaded and an in-flight slot is free.
module pep_ks_cmd_sched #(
  parameter int CMD_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ENQ_MAX     = 4,
  parameter int KSK_SLOT_NB = 2
) (
  input  logic                               clk,
  input  logic                               a_rst_n,
  input  logic [CMD_W-1:0]                   seq_cmd,
  input  logic                               seq_cmd_vld,
  output logic                               seq_cmd_rdy,
  input  logic                               ks_seq_cmd_enquiry,
  output logic [CMD_W-1:0]                   seq_ks_cmd,
  output logic                               seq_ks_cmd_avail,
  input  logic                               inc_ksk_wr_ptr,
  input  logic                               inc_ksk_rd_ptr,
  input  logic                               flush,
  output logic [$clog2(KSK_SLOT_NB+1)-1:0]   ksk_credit,
  output logic [$clog2(KSK_SLOT_NB+1)-1:0]   outstanding,
  output logic [2:0]                         error
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENQ_W  = $clog2(ENQ_MAX + 1);
  localparam int CNT_W  = $clog2(KSK_SLOT_NB + 1);

  localparam logic [FCNT_W-1:0] FIFO_FULL_C = FCNT_W'(FIFO_DEPTH);
  localparam logic [ENQ_W-1:0]  ENQ_MAX_C   = ENQ_W'(ENQ_MAX);
  localparam logic [CNT_W-1:0]  SLOT_MAX_C  = CNT_W'(KSK_SLOT_NB);

  logic [CMD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fill_q, fill_d;
  logic [ENQ_W-1:0]  enq_cnt_q, enq_cnt_d;
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [2:0]        error_q, error_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              avail_q, avail_d;
  logic              active_q;

  logic push;
  logic issue;
  logic enq_ovf;
  logic credit_ovf;
  logic rd_unf;

  // active_q keeps the sequencer stalled until the first clock after reset release
  assign seq_cmd_rdy = active_q && (fill_q != FIFO_FULL_C);

  always_comb begin
    push  = seq_cmd_vld && seq_cmd_rdy && !flush;
    issue = !flush && (fill_q != '0) && (enq_cnt_q != '0) &&
            (credit_q != '0) && (outst_q < SLOT_MAX_C);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   fill_d = fill_q + FCNT_W'(1);
        2'b01:   fill_d = fill_q - FCNT_W'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_comb begin
    enq_cnt_d = enq_cnt_q;
    enq_ovf   = 1'b0;
    if (flush) begin
      enq_cnt_d = '0;
    end else if (ks_seq_cmd_enquiry && !issue) begin
      if (enq_cnt_q == ENQ_MAX_C) begin
        enq_ovf = 1'b1;
      end else begin
        enq_cnt_d = enq_cnt_q + ENQ_W'(1);
      end
    end else if (!ks_seq_cmd_enquiry && issue) begin
      enq_cnt_d = enq_cnt_q - ENQ_W'(1);
    end
  end

  // Same-cycle increment and decrement cancel; issue can never underflow credit
  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    if (inc_ksk_wr_ptr && !issue) begin
      if (credit_q == SLOT_MAX_C) begin
        credit_ovf = 1'b1;
      end else begin
        credit_d = credit_q + CNT_W'(1);
      end
    end else if (!inc_ksk_wr_ptr && issue) begin
      credit_d = credit_q - CNT_W'(1);
    end
  end

  always_comb begin
    outst_d = outst_q;
    rd_unf  = 1'b0;
    if (issue && !inc_ksk_rd_ptr) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (inc_ksk_rd_ptr && !issue) begin
      if (outst_q == '0) begin
        rd_unf = 1'b1;
      end else begin
        outst_d = outst_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    error_d = error_q | {rd_unf, credit_ovf, enq_ovf};
    avail_d = issue;
    cmd_d   = issue ? mem_q[rd_ptr_q] : cmd_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= seq_cmd;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      enq_cnt_q <= '0;
      credit_q  <= '0;
      outst_q   <= '0;
      error_q   <= '0;
      cmd_q     <= '0;
      avail_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      enq_cnt_q <= enq_cnt_d;
      credit_q  <= credit_d;
      outst_q   <= outst_d;
      error_q   <= error_d;
      cmd_q     <= cmd_d;
      avail_q   <= avail_d;
      active_q  <= 1'b1;
    end
  end

  assign seq_ks_cmd       = cmd_q;
  assign seq_ks_cmd_avail = avail_q;
  assign ksk_credit       = credit_q;
  assign outstanding      = outst_q;
  assign error            = error_q;

endmodule
